audio_codec_serdes: RTL and testbench

AUDIO_CODEC_SERDES -- requirements
Module: audio_codec_serdes

---
 rtl/audio_codec_serdes.sv | 166 ++++++++++++++++
 tb/tb_audio_codec_serdes.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/audio_codec_serdes.sv
// rtl/audio_codec_serdes.sv - clock-master stereo serial audio transmitter/receiver
// Generates BCLK/LRCK, serialises playback samples and deserialises capture samples.
module audio_codec_serdes #(
   parameter int DATA_WIDTH = 16,
   parameter int SLOT_BITS  = 16,
   parameter int BCLK_DIV   = 4,
   parameter int MODE       = 0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] play_data_l,
   input  logic [DATA_WIDTH-1:0] play_data_r,
   input  logic                  play_valid,
   output logic                  play_ready,
   output logic [DATA_WIDTH-1:0] cap_data_l,
   output logic [DATA_WIDTH-1:0] cap_data_r,
   output logic                  cap_valid,
   output logic                  underrun,
   input  logic                  underrun_clr,
   output logic                  AUD_BCLK,
   output logic                  AUD_DACLRCK,
   output logic                  AUD_ADCLRCK,
   output logic                  AUD_DACDAT,
   input  logic                  AUD_ADCDAT
);

   localparam int BW  = $clog2(2 * BCLK_DIV);
   localparam int CW  = $clog2(2 * SLOT_BITS);
   localparam int PAD = SLOT_BITS - DATA_WIDTH - MODE;

   localparam logic [BW-1:0] BCLK_LAST = BW'(2 * BCLK_DIV - 1);
   localparam logic [BW-1:0] BCLK_RISE = BW'(BCLK_DIV - 1);
   localparam logic [BW-1:0] BCLK_HIGH = BW'(BCLK_DIV);
   localparam logic [CW-1:0] BIT_LAST  = CW'(2 * SLOT_BITS - 1);
   localparam logic [CW-1:0] SLOT_LEN  = CW'(SLOT_BITS);
   localparam logic [CW-1:0] FIRST_BIT = CW'(MODE);
   localparam logic [CW-1:0] DATA_LEN  = CW'(DATA_WIDTH);
   localparam logic          LEFT_LVL  = 1'(MODE == 0);

   if (SLOT_BITS < DATA_WIDTH + MODE || BCLK_DIV < 2 || DATA_WIDTH < 8 ||
       DATA_WIDTH > 32 || (MODE != 0 && MODE != 1)) begin : g_param_check
      $error("audio_codec_serdes: invalid parameter combination");
   end

   logic [BW-1:0]         bclk_cnt_q, bclk_cnt_d;
   logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
   logic                  bclk_q, bclk_d;
   logic                  lrck_q, lrck_d;
   logic                  dacdat_q, dacdat_d;
   logic [DATA_WIDTH-1:0] tx_l_q, tx_l_d, tx_r_q, tx_r_d;
   logic [DATA_WIDTH-1:0] rx_l_q, rx_l_d, rx_r_q, rx_r_d;
   logic [DATA_WIDTH-1:0] cap_l_q, cap_l_d, cap_r_q, cap_r_d;
   logic                  cap_valid_q, cap_valid_d;
   logic                  underrun_q, underrun_d;

   logic                     bclk_wrap, frame_end, in_data;
   logic [CW-1:0]            slot_idx;
   logic [SLOT_BITS-1:0]     slot_l, slot_r;
   logic [2*SLOT_BITS-1:0]   frame_vec, frame_mask;

   always_comb begin
      bclk_wrap   = (bclk_cnt_q == BCLK_LAST);
      frame_end   = bclk_wrap && (bit_cnt_q == BIT_LAST);
      bclk_cnt_d  = bclk_wrap ? '0 : bclk_cnt_q + 1'b1;
      bit_cnt_d   = bit_cnt_q;
      if (bclk_wrap) begin
         bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
      end

      tx_l_d      = tx_l_q;
      tx_r_d      = tx_r_q;
      underrun_d  = underrun_q;
      if (underrun_clr) begin
         underrun_d = 1'b0;
      end
      // Set wins over a simultaneous clear, so the load sits after the clear.
      if (frame_end) begin
         if (play_valid) begin
            tx_l_d = play_data_l;
            tx_r_d = play_data_r;
         end else begin
            tx_l_d     = '0;
            tx_r_d     = '0;
            underrun_d = 1'b1;
         end
      end

      bclk_d = (bclk_cnt_d >= BCLK_HIGH);
      lrck_d = (bit_cnt_d < SLOT_LEN) ? LEFT_LVL : ~LEFT_LVL;

      // Slot image: MODE leading zeros, sample MSB first, trailing zero pad.
      slot_l     = SLOT_BITS'(tx_l_d) << PAD;
      slot_r     = SLOT_BITS'(tx_r_d) << PAD;
      frame_vec  = {slot_l, slot_r};
      frame_mask = '0;
      frame_mask[2*SLOT_BITS-1] = 1'b1;
      frame_mask = frame_mask >> bit_cnt_d;
      dacdat_d   = dacdat_q;
      if (bclk_wrap) begin
         dacdat_d = |(frame_vec & frame_mask);
      end

      slot_idx = (bit_cnt_q >= SLOT_LEN) ? bit_cnt_q - SLOT_LEN : bit_cnt_q;
      in_data  = ((slot_idx - FIRST_BIT) < DATA_LEN);
      rx_l_d   = rx_l_q;
      rx_r_d   = rx_r_q;
      if (bclk_cnt_q == BCLK_RISE && in_data) begin
         if (bit_cnt_q < SLOT_LEN) begin
            rx_l_d = {rx_l_q[DATA_WIDTH-2:0], AUD_ADCDAT};
         end else begin
            rx_r_d = {rx_r_q[DATA_WIDTH-2:0], AUD_ADCDAT};
         end
      end

      cap_l_d     = cap_l_q;
      cap_r_d     = cap_r_q;
      cap_valid_d = frame_end;
      if (frame_end) begin
         cap_l_d = rx_l_q;
         cap_r_d = rx_r_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         bclk_cnt_q  <= '0;
         bit_cnt_q   <= '0;
         bclk_q      <= 1'b0;
         lrck_q      <= LEFT_LVL;
         dacdat_q    <= 1'b0;
         tx_l_q      <= '0;
         tx_r_q      <= '0;
         rx_l_q      <= '0;
         rx_r_q      <= '0;
         cap_l_q     <= '0;
         cap_r_q     <= '0;
         cap_valid_q <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         bclk_cnt_q  <= bclk_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         bclk_q      <= bclk_d;
         lrck_q      <= lrck_d;
         dacdat_q    <= dacdat_d;
         tx_l_q      <= tx_l_d;
         tx_r_q      <= tx_r_d;
         rx_l_q      <= rx_l_d;
         rx_r_q      <= rx_r_d;
         cap_l_q     <= cap_l_d;
         cap_r_q     <= cap_r_d;
         cap_valid_q <= cap_valid_d;
         underrun_q  <= underrun_d;
      end
   end

   assign play_ready  = frame_end;
   assign cap_data_l  = cap_l_q;
   assign cap_data_r  = cap_r_q;
   assign cap_valid   = cap_valid_q;
   assign underrun    = underrun_q;
   assign AUD_BCLK    = bclk_q;
   assign AUD_DACLRCK = lrck_q;
   assign AUD_ADCLRCK = lrck_q;
   assign AUD_DACDAT  = dacdat_q;

endmodule

// File: tb/tb_audio_codec_serdes.sv
// tb/tb_audio_codec_serdes.sv - directed bench for audio_codec_serdes
// Three instances: defaults with DAC->ADC loopback, I2S 24/32 with codec model, fast BCLK timing.
module tb_audio_codec_serdes;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset_n = 1'b0;

   logic [15:0] pd_l0, pd_r0, cl0, cr0;
   logic        pv0, pr0, cv0, ur0, uc0, bclk0, dlr0, alr0, dac0;

   logic [23:0] cl1, cr1;
   logic        pr1, cv1, ur1, bclk1, dlr1, alr1, dac1;
   logic        adc1 = 1'b0;

   logic [15:0] cl2, cr2;
   logic        pr2, cv2, ur2, bclk2, dlr2, alr2, dac2;

   audio_codec_serdes u_dut0 (
      .clk(clk), .reset_n(reset_n),
      .play_data_l(pd_l0), .play_data_r(pd_r0), .play_valid(pv0), .play_ready(pr0),
      .cap_data_l(cl0), .cap_data_r(cr0), .cap_valid(cv0),
      .underrun(ur0), .underrun_clr(uc0),
      .AUD_BCLK(bclk0), .AUD_DACLRCK(dlr0), .AUD_ADCLRCK(alr0),
      .AUD_DACDAT(dac0), .AUD_ADCDAT(dac0));

   audio_codec_serdes #(.DATA_WIDTH(24), .SLOT_BITS(32), .BCLK_DIV(4), .MODE(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n),
      .play_data_l(24'h0), .play_data_r(24'h0), .play_valid(1'b0), .play_ready(pr1),
      .cap_data_l(cl1), .cap_data_r(cr1), .cap_valid(cv1),
      .underrun(ur1), .underrun_clr(1'b0),
      .AUD_BCLK(bclk1), .AUD_DACLRCK(dlr1), .AUD_ADCLRCK(alr1),
      .AUD_DACDAT(dac1), .AUD_ADCDAT(adc1));

   audio_codec_serdes #(.DATA_WIDTH(16), .SLOT_BITS(20), .BCLK_DIV(2), .MODE(0)) u_dut2 (
      .clk(clk), .reset_n(reset_n),
      .play_data_l(16'h0), .play_data_r(16'h0), .play_valid(1'b0), .play_ready(pr2),
      .cap_data_l(cl2), .cap_data_r(cr2), .cap_valid(cv2),
      .underrun(ur2), .underrun_clr(1'b0),
      .AUD_BCLK(bclk2), .AUD_DACLRCK(dlr2), .AUD_ADCLRCK(alr2),
      .AUD_DACDAT(dac2), .AUD_ADCDAT(1'b0));

   // I2S slave codec: counts BCLK falls since the last LRCK change, MSB one bit late.
   localparam logic [23:0] L1 = 24'h800001;
   localparam logic [23:0] R1 = 24'h7FFFFE;
   int          k1 = 0;
   logic        prev_b1 = 1'b0, prev_lr1 = 1'b0;
   logic [23:0] w1;
   always @(posedge clk) begin
      #2;
      if (!reset_n) begin
         k1 = 0; prev_b1 = 1'b0; prev_lr1 = 1'b0; adc1 = 1'b0;
      end else begin
         if (prev_b1 && !bclk1) begin
            if (alr1 != prev_lr1) k1 = 0;
            else k1 = k1 + 1;
            prev_lr1 = alr1;
            w1 = (alr1 ? R1 : L1) >> (24 - k1);
            adc1 = (k1 >= 1 && k1 <= 24) ? w1[0] : 1'b0;
         end
         prev_b1 = bclk1;
      end
   end

   int n_cmp = 0, n_bad = 0;
   int rdy_cnt = 0, capv_cnt = 0, cv1_cnt = 0, cv1_double = 0, cyc = 0;
   int last_rdy2 = -1, per2 = 0, last_lr2 = -1, lr_int2 = 0, last_rise2 = -1, rise_per2 = 0;
   logic cv1_prev = 1'b0, prev_lr2 = 1'b1, prev_b2 = 1'b0;
   logic [31:0] bits;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         cyc++;
         if (pr0) rdy_cnt++;
         if (cv0) capv_cnt++;
         if (cv1) begin
            cv1_cnt++;
            if (cv1_prev) cv1_double++;
         end
         cv1_prev = cv1;
         if (pr2) begin
            if (last_rdy2 >= 0) per2 = cyc - last_rdy2;
            last_rdy2 = cyc;
         end
         if (dlr2 != prev_lr2) begin
            if (last_lr2 >= 0) lr_int2 = cyc - last_lr2;
            last_lr2 = cyc;
         end
         prev_lr2 = dlr2;
         if (bclk2 && !prev_b2) begin
            if (last_rise2 >= 0) rise_per2 = cyc - last_rise2;
            last_rise2 = cyc;
         end
         prev_b2 = bclk2;
      end
   endtask

   // Samples DACDAT mid-high-phase of each BCLK; ends in the frame-end cycle.
   task automatic cap_frame(input int first, output logic [31:0] fb);
      rdy_cnt = 0;
      capv_cnt = 0;
      fb = '0;
      tick(first);
      fb = {fb[30:0], dac0};
      for (int b = 1; b < 32; b++) begin
         tick(8);
         fb = {fb[30:0], dac0};
      end
      tick(3);
      check("ready_at_frame_end", pr0, 1);
      check("ready_pulses_per_frame", rdy_cnt, 1);
   endtask

   initial begin
      pv0 = 1'b1; pd_l0 = 16'hA5C3; pd_r0 = 16'h5A3C; uc0 = 1'b0;
      tick(3);
      check("rst_bclk", bclk0, 0);
      check("rst_daclrck", dlr0, 1);
      check("rst_adclrck", alr0, 1);
      check("rst_dacdat", dac0, 0);
      check("rst_ready", pr0, 0);
      check("rst_cap_valid", cv0, 0);
      check("rst_cap_l", cl0, 0);
      check("rst_cap_r", cr0, 0);
      check("rst_underrun", ur0, 0);
      check("rst_i2s_lrck", dlr1, 0);
      reset_n = 1'b1;

      cap_frame(4, bits);
      check("f0_zeros", bits, 32'h0);
      check("f0_no_cap_valid", capv_cnt, 0);
      check("f0_no_underrun", ur0, 0);

      cap_frame(5, bits);
      check("f1_data", bits, 32'hA5C35A3C);
      check("f1_cap_valid_once", capv_cnt, 1);
      check("f1_cap_l", cl0, 16'h0);
      check("f1_cap_r", cr0, 16'h0);

      pv0 = 1'b0;
      cap_frame(5, bits);
      check("f2_underrun_zeros", bits, 32'h0);
      check("f2_underrun_set", ur0, 1);
      check("f2_cap_l", cl0, 16'hA5C3);
      check("f2_cap_r", cr0, 16'h5A3C);
      check("i2s_cap_valid_count", cv1_cnt, 1);
      check("i2s_cap_valid_single", cv1_double, 0);
      check("i2s_cap_l", cl1, 24'h800001);
      check("i2s_cap_r", cr1, 24'h7FFFFE);
      check("fast_frame_period", per2, 160);
      check("fast_lrck_interval", lr_int2, 80);
      check("fast_bclk_period", rise_per2, 4);

      pv0 = 1'b1; pd_l0 = 16'h8000; pd_r0 = 16'h0001;
      cap_frame(5, bits);
      check("f3_data", bits, 32'h80000001);
      check("f3_underrun_sticky", ur0, 1);
      check("f3_cap_l", cl0, 16'h0);

      uc0 = 1'b1; tick(1); uc0 = 1'b0;
      check("underrun_cleared", ur0, 0);
      cap_frame(4, bits);
      check("f4_data_held", bits, 32'h80000001);
      check("f4_cap_l", cl0, 16'h8000);
      check("f4_cap_r", cr0, 16'h0001);
      check("f4_no_underrun", ur0, 0);

      pv0 = 1'b0; uc0 = 1'b1; tick(1); uc0 = 1'b0; pv0 = 1'b1;
      check("set_beats_clear", ur0, 1);
      cap_frame(4, bits);
      check("f5_zeros", bits, 32'h0);

      tick(1 + 8 * 20 + 4);
      check("right_slot_daclrck", dlr0, 0);
      check("right_slot_adclrck", alr0, 0);
      reset_n = 1'b0;
      capv_cnt = 0;
      tick(3);
      check("midrst_bclk", bclk0, 0);
      check("midrst_lrck", dlr0, 1);
      check("midrst_dacdat", dac0, 0);
      check("midrst_ready", pr0, 0);
      check("midrst_cap_valid", cv0, 0);
      check("midrst_underrun", ur0, 0);
      check("midrst_no_cap_pulse", capv_cnt, 0);
      pd_l0 = 16'hFFFF; pd_r0 = 16'hFFFF;
      reset_n = 1'b1;

      cap_frame(4, bits);
      check("postrst_zeros", bits, 32'h0);
      check("postrst_no_cap_valid", capv_cnt, 0);
      check("postrst_no_underrun", ur0, 0);
      cap_frame(5, bits);
      check("postrst_data", bits, 32'hFFFFFFFF);
      check("postrst_cap_valid", capv_cnt, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
